placement_cost_eval: RTL and testbench

- Stage directly downstream of the placement engine.
- After placement finishes, it streams the edge list (A/B node ROMs) and reads each endpoint's X/Y from the pos_X/pos_Y RAMs.
- Accumulates Manhattan wirelength, 1-hop cost and error counters, then reports them with a start/done handshake.
- Replaces the inline evaluation loop so the placer and the evaluator can be reused independently.

---
 rtl/placement_cost_eval.sv | 189 ++++++++++++++++++
 tb/tb_placement_cost_eval.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/placement_cost_eval.sv
// placement_cost_eval: streams the placed edge list and accumulates wirelength, 1-hop cost and error counts
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   start / busy / done   start pulse accepted in IDLE, busy while evaluating, one-cycle done pulse
//   reEA, reEB, addrE     edge ROM read (shared edge index); doutEA/doutEB return source/sink node ids
//   rePX, rePY, addrP     position RAM read (shared node id); doutPX/doutPY return signed X/Y, -1 = unplaced
//   sum, sum_1hop         saturating totals of (dx+dy-1) and (ceil(dx/2)+ceil(dy/2)-1)
//   n_unplaced, n_overlap edges with an unplaced/out-of-range endpoint, edges with dx+dy==0
// Optional macro PLACEMENT_COST_MAX_EN adds max_len/max_idx: longest valid dx+dy and first edge reaching it.
module placement_cost_eval #(
    parameter int N_EDGE = 79,
    parameter int N      = 9,
    parameter int W      = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    output logic         busy,
    output logic         done,
    output logic         reEA,
    output logic         reEB,
    output logic [W-1:0] addrE,
    input  logic [W-1:0] doutEA,
    input  logic [W-1:0] doutEB,
    output logic         rePX,
    output logic         rePY,
    output logic [W-1:0] addrP,
    input  logic [W-1:0] doutPX,
    input  logic [W-1:0] doutPY,
`ifdef PLACEMENT_COST_MAX_EN
    output logic [W-1:0] max_len,
    output logic [W-1:0] max_idx,
`endif
    output logic [W-1:0] sum,
    output logic [W-1:0] sum_1hop,
    output logic [W-1:0] n_unplaced,
    output logic [W-1:0] n_overlap
);
    typedef enum logic [3:0] {
        IDLE, RD_E, WAIT_E, RD_A, WAIT_A, LAT_A, RD_B, WAIT_B, LAT_B, CALC0, CALC1, ACC, FIN
    } state_t;
    localparam logic [W:0] SAT = {2'b00, {(W-1){1'b1}}};
    state_t       r_state;
    logic         r_busy, r_done, r_re_e, r_re_p, r_bad;
    logic [W-1:0] r_addr_e, r_addr_p, r_node_b, r_ax, r_ay, r_bx, r_by, r_dx, r_dy, r_cw, r_c1;
    logic [W-1:0] r_sum, r_sum_1h, r_n_unpl, r_n_ovl;
    logic [W-1:0] w_ddx, w_ddy, w_len, w_c1;
    logic [W:0]   w_sum_n, w_s1_n;
    logic         w_skip;
`ifdef PLACEMENT_COST_MAX_EN
    logic [W-1:0] r_len, r_max_len, r_max_idx;
    assign max_len = r_max_len;
    assign max_idx = r_max_idx;
`endif
    assign w_ddx   = r_ax - r_bx;
    assign w_ddy   = r_ay - r_by;
    assign w_len   = r_dx + r_dy;
    assign w_c1    = (r_dx >> 1) + W'(r_dx[0]) + (r_dy >> 1) + W'(r_dy[0]) - W'(1);
    assign w_skip  = r_bad || (w_len == '0);
    // one extra bit so the saturation test sees any overflow past 2^(W-1)-1
    assign w_sum_n = {1'b0, r_sum} + {1'b0, r_cw};
    assign w_s1_n  = {1'b0, r_sum_1h} + {1'b0, r_c1};
    assign busy       = r_busy;
    assign done       = r_done;
    assign reEA       = r_re_e;
    assign reEB       = r_re_e;
    assign addrE      = r_addr_e;
    assign rePX       = r_re_p;
    assign rePY       = r_re_p;
    assign addrP      = r_addr_p;
    assign sum        = r_sum;
    assign sum_1hop   = r_sum_1h;
    assign n_unplaced = r_n_unpl;
    assign n_overlap  = r_n_ovl;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_re_e   <= 1'b0;
            r_re_p   <= 1'b0;
            r_bad    <= 1'b0;
            r_addr_e <= '0;
            r_addr_p <= '0;
            r_node_b <= '0;
            r_ax     <= '0;
            r_ay     <= '0;
            r_bx     <= '0;
            r_by     <= '0;
            r_dx     <= '0;
            r_dy     <= '0;
            r_cw     <= '0;
            r_c1     <= '0;
            r_sum    <= '0;
            r_sum_1h <= '0;
            r_n_unpl <= '0;
            r_n_ovl  <= '0;
`ifdef PLACEMENT_COST_MAX_EN
            r_len     <= '0;
            r_max_len <= '0;
            r_max_idx <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            r_re_e <= 1'b0;
            r_re_p <= 1'b0;
            case (r_state)
                IDLE: begin
                    // the done cycle is still IDLE, so a start coinciding with done is dropped here
                    if (start && !r_done) begin
                        r_busy   <= 1'b1;
                        r_addr_e <= '0;
                        r_sum    <= '0;
                        r_sum_1h <= '0;
                        r_n_unpl <= '0;
                        r_n_ovl  <= '0;
`ifdef PLACEMENT_COST_MAX_EN
                        r_max_len <= '0;
                        r_max_idx <= '0;
`endif
                        r_re_e   <= (N_EDGE != 0);
                        r_state  <= (N_EDGE == 0) ? FIN : RD_E;
                    end
                end
                RD_E:   r_state <= WAIT_E;
                WAIT_E: begin
                    r_node_b <= doutEB;
                    r_addr_p <= doutEA;
                    r_re_p   <= 1'b1;
                    r_state  <= RD_A;
                end
                RD_A:   r_state <= WAIT_A;
                WAIT_A: begin
                    r_ax    <= doutPX;
                    r_ay    <= doutPY;
                    r_state <= LAT_A;
                end
                LAT_A: begin
                    r_addr_p <= r_node_b;
                    r_re_p   <= 1'b1;
                    r_state  <= RD_B;
                end
                RD_B:   r_state <= WAIT_B;
                WAIT_B: begin
                    r_bx    <= doutPX;
                    r_by    <= doutPY;
                    r_state <= LAT_B;
                end
                LAT_B:  r_state <= CALC0;
                CALC0: begin
                    r_dx    <= w_ddx[W-1] ? -w_ddx : w_ddx;
                    r_dy    <= w_ddy[W-1] ? -w_ddy : w_ddy;
                    // unsigned compare: negative coordinates look huge and fail the range test too
                    r_bad   <= (r_ax >= W'(N)) || (r_ay >= W'(N)) || (r_bx >= W'(N)) || (r_by >= W'(N));
                    r_state <= CALC1;
                end
                CALC1: begin
                    r_n_unpl <= r_n_unpl + W'(r_bad);
                    r_n_ovl  <= r_n_ovl + W'(!r_bad && (w_len == '0));
                    r_cw     <= w_skip ? '0 : w_len - W'(1);
                    r_c1     <= w_skip ? '0 : w_c1;
`ifdef PLACEMENT_COST_MAX_EN
                    r_len    <= r_bad ? '0 : w_len;
`endif
                    r_state  <= ACC;
                end
                ACC: begin
                    r_sum    <= (w_sum_n > SAT) ? SAT[W-1:0] : w_sum_n[W-1:0];
                    r_sum_1h <= (w_s1_n > SAT) ? SAT[W-1:0] : w_s1_n[W-1:0];
`ifdef PLACEMENT_COST_MAX_EN
                    if (r_len > r_max_len) begin
                        r_max_len <= r_len;
                        r_max_idx <= r_addr_e;
                    end
`endif
                    r_addr_e <= r_addr_e + W'(1);
                    r_re_e   <= (r_addr_e + W'(1) != W'(N_EDGE));
                    r_state  <= (r_addr_e + W'(1) == W'(N_EDGE)) ? FIN : RD_E;
                end
                FIN: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_placement_cost_eval.sv
// tb_placement_cost_eval: directed images for a 79-edge and a 1-edge evaluator, scoreboard on done
module tb_placement_cost_eval;
    typedef struct { int sum; int s1; int nu; int no; int ml; int mi; int bl; } exp_t;
    logic clk = 1'b0, reset = 1'b1, start0 = 1'b0, start1 = 1'b0;
    logic busy0, done0, reEA0, reEB0, rePX0, rePY0, busy1, done1, reEA1, reEB1, rePX1, rePY1;
    logic [31:0] addrE0, addrP0, dEA0, dEB0, dPX0, dPY0, sum0, sh0, nu0, no0;
    logic [31:0] addrE1, addrP1, dEA1, dEB1, dPX1, dPY1, sum1, sh1, nu1, no1;
`ifdef PLACEMENT_COST_MAX_EN
    logic [31:0] ml0, mi0, ml1, mi1;
`endif
    logic [31:0] ea[128], eb[128], px[128], py[128];
    exp_t q0[$], q1[$];
    exp_t m0, m1;
    int n_vec = 0, n_err = 0, got0 = 0, got1 = 0, t0 = 0, t1 = 0, bc0 = 0, bc1 = 0;

    always #5 clk = ~clk;

    placement_cost_eval u0 (
        .clk(clk), .reset(reset), .start(start0), .busy(busy0), .done(done0),
        .reEA(reEA0), .reEB(reEB0), .addrE(addrE0), .doutEA(dEA0), .doutEB(dEB0),
        .rePX(rePX0), .rePY(rePY0), .addrP(addrP0), .doutPX(dPX0), .doutPY(dPY0),
`ifdef PLACEMENT_COST_MAX_EN
        .max_len(ml0), .max_idx(mi0),
`endif
        .sum(sum0), .sum_1hop(sh0), .n_unplaced(nu0), .n_overlap(no0)
    );

    placement_cost_eval #(.N_EDGE(1)) u1 (
        .clk(clk), .reset(reset), .start(start1), .busy(busy1), .done(done1),
        .reEA(reEA1), .reEB(reEB1), .addrE(addrE1), .doutEA(dEA1), .doutEB(dEB1),
        .rePX(rePX1), .rePY(rePY1), .addrP(addrP1), .doutPX(dPX1), .doutPY(dPY1),
`ifdef PLACEMENT_COST_MAX_EN
        .max_len(ml1), .max_idx(mi1),
`endif
        .sum(sum1), .sum_1hop(sh1), .n_unplaced(nu1), .n_overlap(no1)
    );

    // synchronous memories: sample re/addr on the edge, data appear after it and hold
    always @(posedge clk) begin
        if (reEA0) dEA0 <= ea[addrE0[6:0]];
        if (reEB0) dEB0 <= eb[addrE0[6:0]];
        if (rePX0) dPX0 <= px[addrP0[6:0]];
        if (rePY0) dPY0 <= py[addrP0[6:0]];
        if (reEA1) dEA1 <= ea[addrE1[6:0]];
        if (reEB1) dEB1 <= eb[addrE1[6:0]];
        if (rePX1) dPX1 <= px[addrP1[6:0]];
        if (rePY1) dPY1 <= py[addrP1[6:0]];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done0) begin
            if (q0.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL u0 done: got a done pulse expected none (no run pending)");
            end else begin
                m0 = q0.pop_front();
                chk("u0 sum", sum0, m0.sum);
                chk("u0 sum_1hop", sh0, m0.s1);
                chk("u0 n_unplaced", nu0, m0.nu);
                chk("u0 n_overlap", no0, m0.no);
                chk("u0 busy_cycles", bc0, m0.bl);
`ifdef PLACEMENT_COST_MAX_EN
                chk("u0 max_len", ml0, m0.ml);
                chk("u0 max_idx", mi0, m0.mi);
`endif
            end
            got0++;
        end
        bc0 = busy0 ? bc0 + 1 : 0;
    end

    always @(negedge clk) begin
        if (done1) begin
            if (q1.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL u1 done: got a done pulse expected none (no run pending)");
            end else begin
                m1 = q1.pop_front();
                chk("u1 sum", sum1, m1.sum);
                chk("u1 sum_1hop", sh1, m1.s1);
                chk("u1 n_unplaced", nu1, m1.nu);
                chk("u1 n_overlap", no1, m1.no);
                chk("u1 busy_cycles", bc1, m1.bl);
`ifdef PLACEMENT_COST_MAX_EN
                chk("u1 max_len", ml1, m1.ml);
                chk("u1 max_idx", mi1, m1.mi);
`endif
            end
            got1++;
        end
        bc1 = busy1 ? bc1 + 1 : 0;
    end

    task automatic setp(input int n, input int x, input int y);
        px[n] = x;
        py[n] = y;
    endtask

    task automatic sete(input int e, input int a, input int b);
        ea[e] = a;
        eb[e] = b;
    endtask

    task automatic load_img(input int k);
        for (int n = 0; n < 128; n++) begin
            ea[n] = 0; eb[n] = 0; px[n] = 0; py[n] = 0;
        end
        if (k == 1) begin
            setp(0, 0, 0); setp(1, 3, 2); setp(2, 5, 5);
            for (int e = 1; e < 79; e++) sete(e, 2, 2);
            sete(0, 0, 1);
        end else if (k == 2) begin
            setp(0, -1, 3); setp(1, 2, 2); setp(2, 4, 4); setp(3, 1, 1); setp(4, 1, 2);
            setp(5, 9, 0); setp(6, 8, 8); setp(7, 0, 0); setp(8, 3, -5);
            for (int e = 6; e < 79; e++) sete(e, 3, 4);
            sete(0, 0, 1); sete(1, 2, 2); sete(2, 3, 4); sete(3, 5, 1); sete(4, 6, 7); sete(5, 1, 8);
        end else if (k == 3) begin
            for (int n = 0; n < 81; n++) setp(n, ((n * 31 + 5) % 81) % 9, ((n * 31 + 5) % 81) / 9);
            px[13] = -1; px[40] = -1; py[77] = 9; py[60] = -3;
            for (int e = 0; e < 79; e++) sete(e, (e * 5 + 1) % 81, (e * 11 + 7) % 81);
        end else begin
            setp(0, 0, 0); setp(1, 1, 1); setp(2, 2, 3); setp(3, 3, 2); setp(4, 1, 2); setp(5, 6, 6);
            for (int e = 4; e < 79; e++) sete(e, 5, 5);
            sete(0, 0, 1); sete(1, 0, 2); sete(2, 0, 3); sete(3, 0, 4);
        end
    endtask

    function automatic exp_t model(input int ne);
        exp_t r;
        int ax, ay, bx, by, dx, dy;
        r = '{0, 0, 0, 0, 0, 0, 11 * ne + 1};
        for (int k = 0; k < ne; k++) begin
            ax = px[ea[k][6:0]]; ay = py[ea[k][6:0]];
            bx = px[eb[k][6:0]]; by = py[eb[k][6:0]];
            dx = (ax > bx) ? ax - bx : bx - ax;
            dy = (ay > by) ? ay - by : by - ay;
            if (ax < 0 || ay < 0 || bx < 0 || by < 0 || ax > 8 || ay > 8 || bx > 8 || by > 8) r.nu++;
            else if (dx + dy == 0) r.no++;
            else begin
                r.sum += dx + dy - 1;
                r.s1 += (dx + 1) / 2 + (dy + 1) / 2 - 1;
                if (dx + dy > r.ml) begin
                    r.ml = dx + dy;
                    r.mi = k;
                end
            end
        end
        return r;
    endfunction

    task automatic go(input exp_t e0, input exp_t e1, input bit both);
        q0.push_back(e0);
        t0++;
        if (both) begin
            q1.push_back(e1);
            t1++;
        end
        @(negedge clk);
        start0 = 1'b1;
        start1 = both;
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic wait_got();
        int k = 0;
        while ((got0 < t0 || got1 < t1) && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk("u0 runs completed", got0, t0);
        chk("u1 runs completed", got1, t1);
    endtask

    initial begin
        int k;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("idle controls", 32'({busy0, done0, reEA0, reEB0, rePX0, rePY0,
                                      busy1, done1, reEA1, reEB1, rePX1, rePY1}), 0);
            chk("idle results", sum0 | sh0 | nu0 | no0 | sum1 | sh1 | nu1 | no1, 0);
        end
        // single edge (0,0)-(3,2); remaining u0 edges all overlap
        load_img(1);
        go('{4, 2, 0, 78, 5, 0, 870}, '{4, 2, 0, 0, 5, 0, 12}, 1'b1);
        wait_got();
        // unplaced, out of range, overlap, adjacent and corner-to-corner edges
        load_img(2);
        go('{15, 7, 3, 1, 16, 4, 870}, '{0, 0, 1, 0, 0, 0, 12}, 1'b1);
        k = 0;
        while (!done0 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        chk("start on done ignored", 32'(busy0), 0);
        wait_got();
        // pseudo-random full image, with a start pulse mid-run that must be ignored
        load_img(3);
        go(model(79), model(1), 1'b1);
        repeat (150) @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        wait_got();
        // abort a run at edge 40, then rerun the same image cleanly
        @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        k = 0;
        while (addrE0 != 40 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        chk("reached edge 40", addrE0, 40);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid reset controls", 32'({busy0, done0, reEA0, reEB0, rePX0, rePY0}), 0);
        chk("mid reset addrE", addrE0, 0);
        chk("mid reset addrP", addrP0, 0);
        chk("mid reset sum", sum0, 0);
        chk("mid reset sum_1hop", sh0, 0);
        chk("mid reset counts", nu0 | no0, 0);
        go(model(79), model(1), 1'b0);
        wait_got();
`ifdef PLACEMENT_COST_MAX_EN
        // edge lengths 2,5,5,3 then overlaps: first maximum is edge 1
        load_img(4);
        go('{11, 6, 0, 75, 5, 1, 870}, '{1, 1, 0, 0, 2, 0, 12}, 1'b1);
        wait_got();
`endif
        repeat (5) @(negedge clk);
        chk("u0 scoreboard drained", 32'(q0.size()), 0);
        chk("u1 scoreboard drained", 32'(q1.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
